// File: rtl/row_stream_pkg.sv
// Shared state encoding and ID formatting for the row-request stream mux.
package row_stream_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_FOOTER = 2'd2
    } mux_state_e;

    // Widest data bus fmt_id can serve; callers cast the result down to their width.
    localparam int FMT_MAX_W = 4096;

    function automatic logic [FMT_MAX_W-1:0] fmt_id(input logic [FMT_MAX_W-1:0] id,
                                                    input int id_width);
        logic [FMT_MAX_W-1:0] mask;
        mask = ~({FMT_MAX_W{1'b1}} << id_width);
        return id & mask;
    endfunction

endpackage

// File: rtl/req_holding_reg.sv
// One-entry request register; accepts a new ID only while empty and out of reset.
module req_holding_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] req_id,
    input  logic             req_valid,
    input  logic             take,
    output logic [WIDTH-1:0] rq_data,
    output logic             rq_valid,
    output logic             ready
);

    assign ready = resetn & ~rq_valid;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rq_data  <= '0;
            rq_valid <= 1'b0;
        end else if (req_valid && ready) begin
            rq_data  <= req_id;
            rq_valid <= 1'b1;
        end else if (take) begin
            rq_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/row_request_mux.sv
// Turns each accepted row request into a header/data/footer TX packet, pulling
// data from the RX streams in round-robin order and tapping one channel to RBF.
//
// state     | meaning
// ST_IDLE   | waiting for a buffered request and a free TX slot to load the header
// ST_DATA   | forwarding BEATS_PER_PACKET beats from RX[sel]
// ST_FOOTER | waiting for a free TX slot to load the footer, then advance sel
module row_request_mux
    import row_stream_pkg::*;
#(
    parameter int REQ_ID_WIDTH     = 32,
    parameter int DATA_WIDTH       = 512,
    parameter int NUM_INPUTS       = 2,
    parameter int BEATS_PER_PACKET = 32,
    parameter int RBF_CHANNEL      = 0
) (
    input  logic                             clk,
    input  logic                             resetn,
    input  logic [REQ_ID_WIDTH-1:0]          REQ_ID_IN,
    input  logic                             REQ_ID_VALID,
    output logic                             READY_FOR_REQ,
    input  logic [NUM_INPUTS*DATA_WIDTH-1:0] AXIS_RX_TDATA,
    input  logic [NUM_INPUTS-1:0]            AXIS_RX_TVALID,
    output logic [NUM_INPUTS-1:0]            AXIS_RX_TREADY,
    output logic [DATA_WIDTH-1:0]            AXIS_TX_TDATA,
    output logic                             AXIS_TX_TVALID,
    output logic                             AXIS_TX_TLAST,
    input  logic                             AXIS_TX_TREADY,
    output logic [DATA_WIDTH-1:0]            AXIS_RBF_TDATA,
    output logic                             AXIS_RBF_TVALID,
    input  logic                             AXIS_RBF_TREADY,
    output logic [31:0]                      PACKETS_SENT
);

    localparam int SEL_W = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
    localparam int CNT_W = $clog2(BEATS_PER_PACKET + 1);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_INPUTS - 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BEATS_PER_PACKET);

    mux_state_e              state, state_nxt;
    logic [SEL_W-1:0]        sel;
    logic [CNT_W-1:0]        countdown;
    logic [REQ_ID_WIDTH-1:0] req_id;
    logic [REQ_ID_WIDTH-1:0] rq_data;
    logic                    rq_valid;
    logic                    tx_free, rbf_free, tap;
    logic [DATA_WIDTH-1:0]   rx_data;
    logic                    rx_valid_sel;
    logic                    rx_go, rx_hs, load_hdr, load_ftr;

    req_holding_reg #(.WIDTH(REQ_ID_WIDTH)) u_req_reg (
        .clk       (clk),
        .resetn    (resetn),
        .req_id    (REQ_ID_IN),
        .req_valid (REQ_ID_VALID),
        .take      (load_hdr),
        .rq_data   (rq_data),
        .rq_valid  (rq_valid),
        .ready     (READY_FOR_REQ)
    );

    assign tx_free      = ~AXIS_TX_TVALID | AXIS_TX_TREADY;
    assign rbf_free     = ~AXIS_RBF_TVALID | AXIS_RBF_TREADY;
    assign tap          = (int'(sel) == RBF_CHANNEL);
    assign rx_data      = AXIS_RX_TDATA[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
    assign rx_valid_sel = AXIS_RX_TVALID[sel];
    assign rx_hs        = rx_go & rx_valid_sel;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load_hdr  = 1'b0;
        load_ftr  = 1'b0;
        rx_go     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (rq_valid && tx_free) begin
                    load_hdr  = 1'b1;
                    state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                // A tap channel may only advance when RBF can take the copy too.
                rx_go = tx_free & (~tap | rbf_free);
                if (rx_go && rx_valid_sel && countdown == CNT_W'(1)) state_nxt = ST_FOOTER;
            end
            ST_FOOTER: begin
                if (tx_free) begin
                    load_ftr  = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        AXIS_RX_TREADY      = '0;
        AXIS_RX_TREADY[sel] = rx_go;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            AXIS_TX_TDATA   <= '0;
            AXIS_TX_TVALID  <= 1'b0;
            AXIS_TX_TLAST   <= 1'b0;
            AXIS_RBF_TDATA  <= '0;
            AXIS_RBF_TVALID <= 1'b0;
            sel             <= '0;
            countdown       <= '0;
            req_id          <= '0;
            PACKETS_SENT    <= '0;
        end else begin
            if (load_hdr) begin
                AXIS_TX_TDATA  <= DATA_WIDTH'(fmt_id(FMT_MAX_W'(rq_data), REQ_ID_WIDTH));
                AXIS_TX_TVALID <= 1'b1;
                AXIS_TX_TLAST  <= 1'b0;
                req_id         <= rq_data;
                countdown      <= CNT_LOAD;
            end else if (rx_hs) begin
                AXIS_TX_TDATA  <= rx_data;
                AXIS_TX_TVALID <= 1'b1;
                AXIS_TX_TLAST  <= 1'b0;
                countdown      <= countdown - CNT_W'(1);
            end else if (load_ftr) begin
                AXIS_TX_TDATA  <= DATA_WIDTH'(fmt_id(FMT_MAX_W'(req_id), REQ_ID_WIDTH));
                AXIS_TX_TVALID <= 1'b1;
                AXIS_TX_TLAST  <= 1'b1;
                sel            <= (sel == SEL_LAST) ? '0 : sel + SEL_W'(1);
            end else if (tx_free) begin
                AXIS_TX_TVALID <= 1'b0;
                AXIS_TX_TLAST  <= 1'b0;
            end

            if (rx_hs && tap) begin
                AXIS_RBF_TDATA  <= rx_data;
                AXIS_RBF_TVALID <= 1'b1;
            end else if (AXIS_RBF_TREADY) begin
                AXIS_RBF_TVALID <= 1'b0;
            end

            if (AXIS_TX_TVALID && AXIS_TX_TREADY && AXIS_TX_TLAST)
                PACKETS_SENT <= PACKETS_SENT + 32'd1;
        end
    end

endmodule

// File: tb/tb_row_request_mux.sv
// Scoreboard bench for row_request_mux: expected packets are queued when a
// request is accepted and compared beat by beat as TX/RBF hand them over.
module tb_row_request_mux;

    localparam int RW     = 32;
    localparam int DW     = 64;
    localparam int NI     = 3;
    localparam int BPP    = 32;
    localparam int RBF_CH = 0;
    localparam int CW     = DW + 1;

    typedef logic [CW-1:0] cw_t;
    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    logic             clk = 1'b0;
    logic             resetn = 1'b0;
    logic [RW-1:0]    REQ_ID_IN;
    logic             REQ_ID_VALID;
    logic             READY_FOR_REQ;
    logic [NI*DW-1:0] AXIS_RX_TDATA;
    logic [NI-1:0]    AXIS_RX_TVALID;
    logic [NI-1:0]    AXIS_RX_TREADY;
    logic [DW-1:0]    AXIS_TX_TDATA;
    logic             AXIS_TX_TVALID;
    logic             AXIS_TX_TLAST;
    logic             AXIS_TX_TREADY;
    logic [DW-1:0]    AXIS_RBF_TDATA;
    logic             AXIS_RBF_TVALID;
    logic             AXIS_RBF_TREADY;
    logic [31:0]      PACKETS_SENT;

    always #5 clk = ~clk;

    row_request_mux #(
        .REQ_ID_WIDTH     (RW),
        .DATA_WIDTH       (DW),
        .NUM_INPUTS       (NI),
        .BEATS_PER_PACKET (BPP),
        .RBF_CHANNEL      (RBF_CH)
    ) dut (
        .clk             (clk),
        .resetn          (resetn),
        .REQ_ID_IN       (REQ_ID_IN),
        .REQ_ID_VALID    (REQ_ID_VALID),
        .READY_FOR_REQ   (READY_FOR_REQ),
        .AXIS_RX_TDATA   (AXIS_RX_TDATA),
        .AXIS_RX_TVALID  (AXIS_RX_TVALID),
        .AXIS_RX_TREADY  (AXIS_RX_TREADY),
        .AXIS_TX_TDATA   (AXIS_TX_TDATA),
        .AXIS_TX_TVALID  (AXIS_TX_TVALID),
        .AXIS_TX_TLAST   (AXIS_TX_TLAST),
        .AXIS_TX_TREADY  (AXIS_TX_TREADY),
        .AXIS_RBF_TDATA  (AXIS_RBF_TDATA),
        .AXIS_RBF_TVALID (AXIS_RBF_TVALID),
        .AXIS_RBF_TREADY (AXIS_RBF_TREADY),
        .PACKETS_SENT    (PACKETS_SENT)
    );

    beat_t         exp_tx[$];
    logic [DW-1:0] exp_rbf[$];
    logic [RW-1:0] pending[$];

    int errors = 0;
    int checks = 0;
    int exp_ch, exp_pkts;
    int exp_cnt[NI];
    int src_cnt[NI];
    int cyc = 0;
    int req_hs_cyc, first_valid_cyc, tx_hs_count, tx_first, tx_last;
    int rx0_low_cnt, win_tx_hs;
    logic rdy_at1, rdy_at2;
    logic prev_tx_stall, prev_rbf_stall;
    logic [DW-1:0] prev_tx_data, prev_rbf_data;
    logic rand_tready, window_on;

    task automatic check(input string tag, input cw_t obs, input cw_t exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rx_word(input int ch, input int n);
        return {32'hDA7A_0000 | 32'(ch), 32'(n)};
    endfunction

    task automatic drive_rx();
        for (int i = 0; i < NI; i++) AXIS_RX_TDATA[i*DW +: DW] = rx_word(i, src_cnt[i]);
    endtask

    task automatic push_packet(input logic [RW-1:0] id);
        logic [DW-1:0] d;
        exp_tx.push_back('{data: DW'(id), last: 1'b0});
        for (int k = 0; k < BPP; k++) begin
            d = rx_word(exp_ch, exp_cnt[exp_ch]);
            exp_cnt[exp_ch]++;
            exp_tx.push_back('{data: d, last: 1'b0});
            if (exp_ch == RBF_CH) exp_rbf.push_back(d);
        end
        exp_tx.push_back('{data: DW'(id), last: 1'b1});
        exp_ch = (exp_ch + 1) % NI;
        exp_pkts++;
    endtask

    task automatic step();
        logic [NI-1:0] rx_hs;
        logic req_hs;
        beat_t b;
        logic [DW-1:0] r;
        rx_hs  = '0;
        req_hs = 1'b0;
        @(negedge clk);
        cyc++;
        if (resetn) begin
            if (prev_tx_stall) begin
                check("tx_stall_data", cw_t'(AXIS_TX_TDATA), cw_t'(prev_tx_data));
                check("tx_stall_valid", cw_t'(AXIS_TX_TVALID), cw_t'(1));
            end
            if (prev_rbf_stall) begin
                check("rbf_stall_data", cw_t'(AXIS_RBF_TDATA), cw_t'(prev_rbf_data));
                check("rbf_stall_valid", cw_t'(AXIS_RBF_TVALID), cw_t'(1));
            end
            if (AXIS_TX_TVALID && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (cyc == req_hs_cyc + 1) rdy_at1 = READY_FOR_REQ;
            if (cyc == req_hs_cyc + 2) rdy_at2 = READY_FOR_REQ;
            if (AXIS_TX_TVALID && AXIS_TX_TREADY) begin
                if (tx_hs_count == 0) tx_first = cyc;
                tx_last = cyc;
                tx_hs_count++;
                if (window_on) win_tx_hs++;
                check("tx_beat_expected", cw_t'(exp_tx.size() > 0), cw_t'(1));
                if (exp_tx.size() > 0) begin
                    b = exp_tx.pop_front();
                    check("tx_beat", {AXIS_TX_TLAST, AXIS_TX_TDATA}, {b.last, b.data});
                end
            end
            if (AXIS_RBF_TVALID && AXIS_RBF_TREADY) begin
                check("rbf_beat_expected", cw_t'(exp_rbf.size() > 0), cw_t'(1));
                if (exp_rbf.size() > 0) begin
                    r = exp_rbf.pop_front();
                    check("rbf_beat", cw_t'(AXIS_RBF_TDATA), cw_t'(r));
                end
            end
            for (int i = 0; i < NI; i++)
                if (AXIS_RX_TVALID[i] && AXIS_RX_TREADY[i]) rx_hs[i] = 1'b1;
            if (window_on && !AXIS_RX_TREADY[0]) rx0_low_cnt++;
            if (REQ_ID_VALID && READY_FOR_REQ) begin
                req_hs     = 1'b1;
                req_hs_cyc = cyc;
                push_packet(REQ_ID_IN);
            end
            prev_tx_stall  = AXIS_TX_TVALID & ~AXIS_TX_TREADY;
            prev_tx_data   = AXIS_TX_TDATA;
            prev_rbf_stall = AXIS_RBF_TVALID & ~AXIS_RBF_TREADY;
            prev_rbf_data  = AXIS_RBF_TDATA;
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) if (rx_hs[i]) src_cnt[i]++;
        drive_rx();
        if (req_hs) void'(pending.pop_front());
        if (pending.size() > 0) begin
            REQ_ID_VALID = 1'b1;
            REQ_ID_IN    = pending[0];
        end else begin
            REQ_ID_VALID = 1'b0;
        end
        if (rand_tready) AXIS_TX_TREADY = ($urandom_range(0, 9) >= 3);
    endtask

    task automatic apply_reset();
        resetn = 1'b0;
        exp_tx.delete();
        exp_rbf.delete();
        pending.delete();
        REQ_ID_VALID    = 1'b0;
        REQ_ID_IN       = '0;
        AXIS_TX_TREADY  = 1'b1;
        AXIS_RBF_TREADY = 1'b1;
        for (int i = 0; i < NI; i++) begin
            src_cnt[i] = 0;
            exp_cnt[i] = 0;
        end
        drive_rx();
        exp_ch = 0; exp_pkts = 0;
        req_hs_cyc = -10; first_valid_cyc = -1;
        tx_hs_count = 0; tx_first = 0; tx_last = 0;
        rx0_low_cnt = 0; win_tx_hs = 0;
        prev_tx_stall = 1'b0; prev_rbf_stall = 1'b0;
        window_on = 1'b0; rand_tready = 1'b0;
        #1;
        check("rst_tx_valid", cw_t'(AXIS_TX_TVALID), cw_t'(0));
        check("rst_tx_last", cw_t'(AXIS_TX_TLAST), cw_t'(0));
        check("rst_tx_data", cw_t'(AXIS_TX_TDATA), cw_t'(0));
        check("rst_rbf_valid", cw_t'(AXIS_RBF_TVALID), cw_t'(0));
        check("rst_rbf_data", cw_t'(AXIS_RBF_TDATA), cw_t'(0));
        check("rst_pkts", cw_t'(PACKETS_SENT), cw_t'(0));
        check("rst_ready_for_req", cw_t'(READY_FOR_REQ), cw_t'(0));
        check("rst_rx_tready", cw_t'(AXIS_RX_TREADY), cw_t'(0));
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((exp_tx.size() != 0 || exp_rbf.size() != 0 || pending.size() != 0) && n < budget) begin
            step();
            n++;
        end
        repeat (3) step();
        check("tx_drained", cw_t'(exp_tx.size()), cw_t'(0));
        check("rbf_drained", cw_t'(exp_rbf.size()), cw_t'(0));
        check("req_drained", cw_t'(pending.size()), cw_t'(0));
        check("packets_sent", cw_t'(PACKETS_SENT), cw_t'(exp_pkts));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        AXIS_RX_TVALID = '1;
        apply_reset();

        // single request, latency and ready reopening
        step();
        check("ready_after_reset", cw_t'(READY_FOR_REQ), cw_t'(1));
        pending.push_back(32'h1234);
        drain(200);
        check("hdr_latency", cw_t'(first_valid_cyc - req_hs_cyc), cw_t'(2));
        check("ready_while_held", cw_t'(rdy_at1), cw_t'(0));
        check("ready_reopen", cw_t'(rdy_at2), cw_t'(1));
        check("single_contig", cw_t'(tx_last - tx_first + 1), cw_t'(BPP + 2));

        // three back-to-back requests across all channels
        apply_reset();
        pending.push_back(32'h1111);
        pending.push_back(32'h2222);
        pending.push_back(32'h3333);
        drain(400);
        check("b2b_beats", cw_t'(tx_hs_count), cw_t'(3 * (BPP + 2)));
        check("b2b_no_bubble", cw_t'(tx_last - tx_first + 1), cw_t'(3 * (BPP + 2)));

        // random TX backpressure over four packets
        apply_reset();
        rand_tready = 1'b1;
        for (int i = 0; i < 4; i++) pending.push_back(32'hA000_0000 + 32'(i));
        drain(2000);
        rand_tready = 1'b0;
        AXIS_TX_TREADY = 1'b1;
        check("rand_footers", cw_t'(PACKETS_SENT), cw_t'(4));

        // reset in the middle of a channel-1 packet with a request buffered
        apply_reset();
        pending.push_back(32'h0000_00A0);
        pending.push_back(32'h0000_00B1);
        pending.push_back(32'h0000_00C2);
        n = 0;
        while (src_cnt[1] < 15 && n < 300) begin
            step();
            n++;
        end
        check("reach_beat15", cw_t'(src_cnt[1]), cw_t'(15));
        check("req_buffered", cw_t'(READY_FOR_REQ), cw_t'(0));
        check("pkts_before_rst", cw_t'(PACKETS_SENT), cw_t'(1));
        apply_reset();

        // first packet after reset comes from RX0; stall RBF for 10 cycles inside it
        pending.push_back(32'h0000_D00D);
        n = 0;
        while (src_cnt[0] < 12 && n < 100) begin
            step();
            n++;
        end
        check("rbf_win_start", cw_t'(src_cnt[0]), cw_t'(12));
        AXIS_RBF_TREADY = 1'b0;
        window_on = 1'b1;
        repeat (10) step();
        AXIS_RBF_TREADY = 1'b1;
        window_on = 1'b0;
        drain(200);
        check("rx0_stall_cycles", cw_t'(rx0_low_cnt), cw_t'(10));
        check("tx_beats_in_stall", cw_t'(win_tx_hs), cw_t'(1));
        check("rx0_total", cw_t'(src_cnt[0]), cw_t'(BPP));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/row_request_mux.md
# row_request_mux

Parametrised successor of the row-request manager. Each accepted row request produces one TX packet: header beat (request ID), `BEATS_PER_PACKET` data beats from one of `NUM_INPUTS` RX streams, and footer beat (request ID, TLAST). RX streams are used in strict round-robin order. The TX side honours TREADY backpressure on every beat. One selectable channel is also copied into the row-buffer FIFO stream.

## Interface
- `REQ_ID_WIDTH`, 32, request-ID width; must be ≤ `DATA_WIDTH`.
- `DATA_WIDTH`, 512, RX/TX/RBF data width.
- `NUM_INPUTS`, 2, number of RX streams; ≥ 1.
- `BEATS_PER_PACKET`, 32, data beats per packet; ≥ 1.
- `RBF_CHANNEL`, 0, RX index copied to RBF; a value ≥ `NUM_INPUTS` disables the tap.
- `clk` in 1 — single clock; everything is rising-edge.
- `resetn` in 1 — asynchronous, active-low reset.
- `REQ_ID_IN` in REQ_ID_WIDTH — request ID.
- `REQ_ID_VALID` in 1 — request valid.
- `READY_FOR_REQ` out 1 — request ready; equals `resetn & ~rq_valid`.
- `AXIS_RX_TDATA` in NUM_INPUTS*DATA_WIDTH — channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `AXIS_RX_TVALID` in NUM_INPUTS — per-channel valid.
- `AXIS_RX_TREADY` out NUM_INPUTS — per-channel ready.
- `AXIS_TX_TDATA` out DATA_WIDTH; `AXIS_TX_TVALID` out 1; `AXIS_TX_TLAST` out 1; `AXIS_TX_TREADY` in 1.
- `AXIS_RBF_TDATA` out DATA_WIDTH; `AXIS_RBF_TVALID` out 1; `AXIS_RBF_TREADY` in 1.
- `PACKETS_SENT` out 32 — count of footers accepted on TX; wraps modulo 2^32.

## Operation
- Request register: single entry (`rq_data`, `rq_valid`).
  - Loaded on the REQ handshake.
  - Cleared when the FSM loads a header.
- Derived conditions:
  - `tx_free = ~TX_TVALID | TX_TREADY`.
  - `rbf_free = ~RBF_TVALID | RBF_TREADY`.
  - `tap = (sel == RBF_CHANNEL)`.
- FSM states: IDLE, DATA, FOOTER.
- IDLE, when `rq_valid & tx_free`:
  - TX_TDATA ← zero-extended `rq_data`; TVALID ← 1; TLAST ← 0.
  - Latch `req_id`; clear `rq_valid`.
  - Countdown ← `BEATS_PER_PACKET`; go to DATA.
  - If `tx_free` but no request: TVALID ← 0.
- DATA:
  - `AXIS_RX_TREADY[sel] = tx_free & (~tap | rbf_free)`, combinational. All other TREADY bits are 0.
  - On RX handshake: TX_TDATA ← RX data; TVALID ← 1.
  - If `tap`, also RBF_TDATA ← RX data and RBF_TVALID ← 1.
  - Countdown decrements on each handshake; the handshake at countdown = 1 moves the FSM to FOOTER.
  - When `tx_free` but no handshake: TX_TVALID ← 0.
- FOOTER, when `tx_free`:
  - TX_TDATA ← zero-extended `req_id`; TVALID ← 1; TLAST ← 1.
  - `sel` ← (`sel == NUM_INPUTS-1`) ? 0 : `sel+1`.
  - Go to IDLE.
- RBF_TVALID clears when RBF_TREADY is high and no new tap beat is loaded in the same cycle.
- `PACKETS_SENT` increments on each TX handshake with TLAST = 1.

## Timing
- Reset values (asynchronous reset, all outputs):
  - TX_TVALID, TX_TLAST, RBF_TVALID = 0; TX_TDATA, RBF_TDATA = 0.
  - `sel` = 0; state = IDLE; `rq_valid` = 0; `PACKETS_SENT` = 0.
  - READY_FOR_REQ = 0 while `resetn` is low.
- Latency: a REQ handshake at cycle 0 puts the header on TX at cycle 2.
- With TX_TREADY and RX_TVALID held high, a packet is exactly `BEATS_PER_PACKET`+2 consecutive TX beats. The next header follows the footer with no bubble.
- A held request (`rq_valid`=1) keeps READY_FOR_REQ low. The register reopens one cycle after the header load.
- TX and RBF data and valid stay stable while valid is high and ready is low (AXIS rules).
- RBF stall: if RBF_TREADY is low on a tap channel, the RX stream and TX stall together. Tap beats are never dropped.
- Reset mid-packet:
  - The partial packet is abandoned with no footer.
  - The buffered request is discarded.
  - The next packet after reset starts on channel 0.
- NUM_INPUTS = 1: `sel` stays 0.
- BEATS_PER_PACKET = 1: DATA lasts exactly one handshake.
- Countdown width: `$clog2(BEATS_PER_PACKET+1)`.

## Structure
- Shared package `row_stream_pkg` holds:
  - FSM state encoding.
  - A `fmt_id` function that zero-extends an ID to `DATA_WIDTH`.
- Sub-module `req_holding_reg` implements the one-entry request register and READY_FOR_REQ generation.
- RX demultiplexing is an indexed part-select; no sub-module.

## Test plan
- Single request 0x1234, BEATS = 32, all ready/valid high:
  - TX carries 34 beats: 0x1234, RX0 beats 0..31, 0x1234 with TLAST.
  - RBF carries the same 32 data beats.
  - PACKETS_SENT = 1.
- Three back-to-back requests, NUM_INPUTS = 3:
  - Data is sourced RX0, RX1, RX2 in order.
  - No idle cycles between packets.
  - Only the RX0 packet appears on RBF.
- Random TX_TREADY deassertion (~30%) across 4 packets:
  - No beat is lost or duplicated.
  - TDATA is stable during every stall.
  - Footer count = 4.
- RBF_TREADY low for 10 cycles mid-packet on channel 0:
  - RX0_TREADY and TX stall for 10 cycles.
  - All 32 RBF beats delivered in order.
- resetn pulsed low at data beat 15 of a packet with a request buffered:
  - All outputs return to reset values immediately.
  - The next request after reset produces a full packet from RX0.
